seq_frame_tx: RTL and testbench
===============================

// Module: seq_frame_tx
// PURPOSE
//   Serial frame transmitter: the sending end of the single-bit serial link our sequence detectors monitor.
//   Accepts a parallel word over a valid/ready handshake and shifts out, on one line:
//     - a fixed sync preamble (default 1-0-1),
//     - the payload MSB-first,
//     - an optional parity bit,
//     - one guard bit of 0.
//   Drives the detector's data_in directly.
// PARAMETERS
//   DATA_W    8       payload width in bits (>=1)
//   PRE_W     3       preamble length in bits (>=1)
//   PREAMBLE  3'b101  preamble pattern, sent MSB-first
// PORTS
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous, active-low reset (0 = reset)
//   in_valid   in   1       in_data holds a word to send
//   in_ready   out  1       block can accept a word this cycle
//   in_data    in   DATA_W  payload word
//   data_out   out  1       serial line (registered)
//   out_active out  1       high while preamble/payload/parity bits are on data_out
//   frame_done out  1       one-cycle pulse during the guard bit
// BEHAVIOUR
//   - Reset (reset==0, async): state=IDLE, data_out=0, out_active=0, frame_done=0, counters=0, in_ready=1 after release.
//   - FSM states, in order: IDLE -> PRE -> DATA -> [PAR] -> GAP -> IDLE.
//   - Handshake: transfer when in_valid && in_ready. in_ready=1 in IDLE and GAP only, 0 elsewhere.
//     in_valid while busy is ignored; no word is stored.
//   - On the transfer edge: in_data is latched into the shift register, state->PRE, data_out<=PREAMBLE[PRE_W-1].
//     The first frame bit is therefore on data_out in the cycle after acceptance (latency 1).
//   - PRE:  PRE_W cycles carrying PREAMBLE[PRE_W-1]..[0]; then DATA.
//   - DATA: DATA_W cycles carrying payload bit DATA_W-1..0; bit counter wraps to 0; then PAR if enabled, else GAP.
//   - GAP:  data_out=0, out_active=0, frame_done=1 for exactly one cycle.
//     A transfer in GAP goes straight to PRE (back-to-back), otherwise the next state is IDLE.
//   - IDLE: data_out=0, out_active=0, frame_done=0.
//   - Frame period, back-to-back: PRE_W+DATA_W+1 cycles (+1 with parity). No idle bubble between frames.
//   - out_active=1 exactly in PRE/DATA/PAR. in_data may change freely after acceptance.
//   - Reset asserted mid-frame aborts the frame immediately: data_out=0, no frame_done pulse.
//   - Counters are sized $clog2 of max(PRE_W,DATA_W)+1. No other arithmetic.
// CONFIGURATION
//   SEQ_FRAME_TX_PARITY_EN defined:
//     - State PAR is inserted after DATA for one cycle.
//     - data_out = XOR of the latched payload (even parity); out_active=1 during PAR.
//   SEQ_FRAME_TX_PARITY_EN undefined:
//     - No PAR state and no parity logic; DATA goes straight to GAP.
// STRUCTURE
//   - Package seq_tx_pkg:
//     - state enum {IDLE,PRE,DATA,PAR,GAP};
//     - default PREAMBLE constant 3'b101;
//     - GUARD_BIT = 1'b0.
//   - Sub-module seq_tx_piso: parallel-load, MSB-first shift register (load, shift, q_msb, parity_out).
//   - Top level: FSM, counters, output registers.
// TESTING
//   1. Hold reset=0 for 3 cycles, then release:
//      - during reset: data_out=0, out_active=0, frame_done=0;
//      - first cycle after release: in_ready=1.
//   2. Single 0xA5, no parity: data_out from accept+1 = 1,0,1, 1,0,1,0,0,1,0,1, 0 (12 bits).
//      - frame_done is high on the 12th bit only;
//      - feeding data_out to the detector gives its expected hits.
//   3. Present 0xFF then 0x00 with in_valid held:
//      - the second word is accepted in GAP;
//      - its preamble starts the next cycle; period = 12.
//   4. Pulse in_valid with 0x3C mid-DATA of a frame:
//      - in_ready=0, the word is ignored, the current frame is unchanged, the line is idle afterwards.
//   5. Assert reset during DATA bit 4 of 0xA5:
//      - data_out=0 immediately, no frame_done;
//      - after release: IDLE, in_ready=1.
//   6. With SEQ_FRAME_TX_PARITY_EN:
//      - 0xA5 gives a parity bit of 0 before the guard bit; 0x01 gives a parity bit of 1;
//      - period = 13.

Source files
------------

// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial frame transmitter.
`default_nettype none

package seq_tx_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        DATA = 3'd2,
        PAR  = 3'd3,
        GAP  = 3'd4
    } state_e;

    localparam logic [2:0] DEF_PREAMBLE = 3'b101;
    localparam logic       GUARD_BIT    = 1'b0;

endpackage

`default_nettype wire

// File: rtl/seq_tx_piso.sv
// Parallel-load, MSB-first shift register; parity of the loaded word is held
// separately because the payload is shifted away. Parity only with SEQ_FRAME_TX_PARITY_EN.
`default_nettype none

module seq_tx_piso #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              q_msb
`ifdef SEQ_FRAME_TX_PARITY_EN
    ,
    output logic              parity_out
`endif
);

    logic [DATA_W-1:0] sr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= sr << 1;
        end
    end

    assign q_msb = sr[DATA_W-1];

`ifdef SEQ_FRAME_TX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_out <= 1'b0;
        end else if (load) begin
            parity_out <= ^din;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: preamble, MSB-first payload, optional even parity
// (SEQ_FRAME_TX_PARITY_EN), one guard bit. Async active-low reset.
`default_nettype none

module seq_frame_tx
    import seq_tx_pkg::*;
#(
    parameter int               DATA_W   = 8,
    parameter int               PRE_W    = 3,
    parameter logic [PRE_W-1:0] PREAMBLE = DEF_PREAMBLE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              data_out,
    output logic              out_active,
    output logic              frame_done
);

    localparam int MAX_W = (PRE_W > DATA_W) ? PRE_W : DATA_W;
    localparam int CW    = $clog2(MAX_W + 1);

    localparam logic [2:0] ST_IDLE = IDLE;
    localparam logic [2:0] ST_PRE  = PRE;
    localparam logic [2:0] ST_DATA = DATA;
    localparam logic [2:0] ST_GAP  = GAP;
`ifdef SEQ_FRAME_TX_PARITY_EN
    localparam logic [2:0] ST_PAR  = PAR;
`endif

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          shift;
    logic          q_msb;
    logic          pre_next;
    logic [CW-1:0] pre_idx;
`ifdef SEQ_FRAME_TX_PARITY_EN
    logic          parity;
`endif

    assign in_ready = (state == ST_IDLE) || (state == ST_GAP);
    assign accept   = in_valid && in_ready;

    // cnt holds the index of the bit currently on the line and counts down
    assign shift   = ((state == ST_PRE)  && (cnt == '0)) ||
                     ((state == ST_DATA) && (cnt != '0));
    assign pre_idx = cnt - CW'(1);

    always_comb begin
        pre_next = 1'b0;
        for (int i = 0; i < PRE_W; i++) begin
            if (CW'(i) == pre_idx) begin
                pre_next = PREAMBLE[i];
            end
        end
    end

    seq_tx_piso #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .shift      (shift),
        .din        (in_data),
        .q_msb      (q_msb)
`ifdef SEQ_FRAME_TX_PARITY_EN
        ,
        .parity_out (parity)
`endif
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            data_out   <= 1'b0;
            out_active <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE, ST_GAP: begin
                    if (accept) begin
                        state      <= ST_PRE;
                        cnt        <= CW'(PRE_W - 1);
                        data_out   <= PREAMBLE[PRE_W-1];
                        out_active <= 1'b1;
                    end else begin
                        state      <= ST_IDLE;
                        data_out   <= GUARD_BIT;
                        out_active <= 1'b0;
                    end
                end
                ST_PRE: begin
                    if (cnt == '0) begin
                        state    <= ST_DATA;
                        cnt      <= CW'(DATA_W - 1);
                        data_out <= q_msb;
                    end else begin
                        cnt      <= pre_idx;
                        data_out <= pre_next;
                    end
                end
                ST_DATA: begin
                    if (cnt == '0) begin
`ifdef SEQ_FRAME_TX_PARITY_EN
                        state      <= ST_PAR;
                        data_out   <= parity;
`else
                        state      <= ST_GAP;
                        data_out   <= GUARD_BIT;
                        out_active <= 1'b0;
                        frame_done <= 1'b1;
`endif
                    end else begin
                        cnt      <= cnt - CW'(1);
                        data_out <= q_msb;
                    end
                end
`ifdef SEQ_FRAME_TX_PARITY_EN
                ST_PAR: begin
                    state      <= ST_GAP;
                    data_out   <= GUARD_BIT;
                    out_active <= 1'b0;
                    frame_done <= 1'b1;
                end
`endif
                default: begin
                    state      <= ST_IDLE;
                    cnt        <= '0;
                    data_out   <= GUARD_BIT;
                    out_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_frame_tx.sv
// Directed self-checking bench for seq_frame_tx (default parameters).
`default_nettype none

module tb_seq_frame_tx;

`ifdef SEQ_FRAME_TX_PARITY_EN
    localparam int FL = 13;
`else
    localparam int FL = 12;
`endif

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       data_out;
    logic       out_active;
    logic       frame_done;

    int checks   = 0;
    int failures = 0;

    seq_frame_tx dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .data_out   (data_out),
        .out_active (out_active),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line contents, first bit in the MSB
    function automatic logic [FL-1:0] frame_bits(input logic [7:0] w);
`ifdef SEQ_FRAME_TX_PARITY_EN
        return {3'b101, w, ^w, 1'b0};
`else
        return {3'b101, w, 1'b0};
`endif
    endfunction

    task automatic test_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({data_out, out_active, frame_done} !== 3'b000) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got=%b want=000", i, {data_out, out_active, frame_done});
            end
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_single();
        logic [FL-1:0] exp;
`ifdef SEQ_FRAME_TX_PARITY_EN
        exp = 13'b101_10100101_0_0;
`else
        exp = 12'b101_10100101_0;
`endif
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_data = 8'h00;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            checks++;
            if ({data_out, out_active, frame_done} !== {exp[FL-1-i], (i < FL-1), (i == FL-1)}) begin
                failures++;
                $display("FAIL single_bit i=%0d got=%b want=%b", i, {data_out, out_active, frame_done},
                         {exp[FL-1-i], (i < FL-1), (i == FL-1)});
            end
        end
        @(negedge clk);
        checks++;
        if ({in_ready, data_out, frame_done} !== 3'b100) begin
            failures++;
            $display("FAIL single_idle got=%b want=100", {in_ready, data_out, frame_done});
        end
    endtask

    task automatic test_back_to_back();
        logic [FL-1:0] e1, e2;
        e1 = frame_bits(8'hFF);
        e2 = frame_bits(8'h00);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(posedge clk);
        #1 in_data = 8'h00;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            checks++;
            if ({data_out, in_ready} !== {e1[FL-1-i], (i == FL-1)}) begin
                failures++;
                $display("FAIL b2b_first i=%0d got=%b want=%b", i, {data_out, in_ready}, {e1[FL-1-i], (i == FL-1)});
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            checks++;
            if ({data_out, frame_done} !== {e2[FL-1-i], (i == FL-1)}) begin
                failures++;
                $display("FAIL b2b_second i=%0d got=%b want=%b", i, {data_out, frame_done}, {e2[FL-1-i], (i == FL-1)});
            end
        end
        @(negedge clk);
        checks++;
        if ({in_ready, out_active} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_idle got=%b want=10", {in_ready, out_active});
        end
    endtask

    task automatic test_busy_ignore();
        logic [FL-1:0] exp;
        exp = frame_bits(8'hA5);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            if (i == 5) begin
                in_valid = 1'b1;
                in_data  = 8'h3C;
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_ready got=%b want=0", in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
            checks++;
            if (data_out !== exp[FL-1-i]) begin
                failures++;
                $display("FAIL busy_bit i=%0d got=%b want=%b", i, data_out, exp[FL-1-i]);
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({data_out, out_active, frame_done, in_ready} !== 4'b0001) begin
                failures++;
                $display("FAIL busy_after i=%0d got=%b want=0001", i, {data_out, out_active, frame_done, in_ready});
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(posedge clk);
        #1 in_valid = 1'b0;
        // Line index 5 carries payload bit 5 (a 1); reset lands on bit 4
        for (int i = 0; i < 6; i++) @(negedge clk);
        checks++;
        if (data_out !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre got=%b want=1", data_out);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({data_out, out_active, frame_done} !== 3'b000) begin
            failures++;
            $display("FAIL midrst_abort got=%b want=000", {data_out, out_active, frame_done});
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            checks++;
            if ({in_ready, data_out, out_active, frame_done} !== 4'b1000) begin
                failures++;
                $display("FAIL midrst_after i=%0d got=%b want=1000", i, {in_ready, data_out, out_active, frame_done});
            end
        end
    endtask

`ifdef SEQ_FRAME_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] words [2];
        logic       pbit  [2];
        words[0] = 8'hA5; pbit[0] = 1'b0;
        words[1] = 8'h01; pbit[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = words[k];
            @(posedge clk);
            #1 in_valid = 1'b0;
            for (int i = 0; i < FL; i++) begin
                @(negedge clk);
                if (i == FL-2) begin
                    checks++;
                    if ({data_out, out_active} !== {pbit[k], 1'b1}) begin
                        failures++;
                        $display("FAIL parity_bit w=%h got=%b want=%b", words[k], {data_out, out_active}, {pbit[k], 1'b1});
                    end
                end
                if (i == FL-1) begin
                    checks++;
                    if ({data_out, frame_done} !== 2'b01) begin
                        failures++;
                        $display("FAIL parity_guard w=%h got=%b want=01", words[k], {data_out, frame_done});
                    end
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
`ifdef SEQ_FRAME_TX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
